// File: rtl/ex_div_unit_if.sv
// Divider issue/result bundle between the EX stage (master) and the divide unit (slave).
// Carries operands, op select and flush in, busy/stall/done and result back.
interface ex_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, div_op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, div_op_i, rs1_i, rs2_i, flush_i,
    output busy_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/ex_div_unit.sv
// Radix-2 restoring RV32M divider: XLEN+1 cycles (1 for rs2==0/overflow or cache hit), holds the pipe via stall_o.
// `define DIV_RESULT_CACHE_EN adds a last-result cache so a DIV/REM pair on the same operands completes in 1 cycle.
module ex_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_div_unit_if.slave div_if
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q, dsr_q, result_q;
  logic             rem_sel_q, neg1_q, neg2_q, done_q;

  logic            go, last, signed_op, neg1, neg2, fast_zero, fast_ovf;
  logic [XLEN-1:0] abs1, abs2, quo_d, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, trial, rem_d;

  assign go        = (state_q == IDLE) && div_if.start_i && !div_if.flush_i;
  assign last      = (cnt_q == CNT_W'(XLEN - 1));
  assign signed_op = ~div_if.div_op_i[0];
  assign neg1      = signed_op & div_if.rs1_i[XLEN-1];
  assign neg2      = signed_op & div_if.rs2_i[XLEN-1];
  assign abs1      = neg1 ? -div_if.rs1_i : div_if.rs1_i;
  assign abs2      = neg2 ? -div_if.rs2_i : div_if.rs2_i;
  assign fast_zero = (div_if.rs2_i == '0);
  assign fast_ovf  = signed_op && (div_if.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (div_if.rs2_i == '1);

  // One quotient bit per cycle; a set MSB of the trial difference means "restore".
  assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};
  assign rem_d  = trial[XLEN] ? rem_sh : trial;
  assign quo_d  = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign q_fix  = (neg1_q ^ neg2_q) ? -quo_d : quo_d;
  assign r_fix  = neg1_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];

`ifdef DIV_RESULT_CACHE_EN
  logic            c_vld_q, c_sgn_q, sgn_q, hit;
  logic [XLEN-1:0] c_rs1_q, c_rs2_q, c_quo_q, c_rem_q, rs1_q, rs2_q;

  assign hit = c_vld_q && (c_sgn_q == signed_op) &&
               (c_rs1_q == div_if.rs1_i) && (c_rs2_q == div_if.rs2_i);

  // Only a completed CALC fills the cache; fast paths and flushed ops never do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      sgn_q   <= 1'b0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      if (go) begin
        rs1_q <= div_if.rs1_i;
        rs2_q <= div_if.rs2_i;
        sgn_q <= signed_op;
      end
      if ((state_q == CALC) && last && !div_if.flush_i) begin
        c_vld_q <= 1'b1;
        c_sgn_q <= sgn_q;
        c_rs1_q <= rs1_q;
        c_rs2_q <= rs2_q;
        c_quo_q <= q_fix;
        c_rem_q <= r_fix;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_if.flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (div_if.start_i) begin
              rem_sel_q <= div_if.div_op_i[1];
              neg1_q    <= neg1;
              neg2_q    <= neg2;
              rem_q     <= '0;
              quo_q     <= abs1;
              dsr_q     <= abs2;
              cnt_q     <= '0;
              if (fast_zero) begin
                result_q <= div_if.div_op_i[1] ? div_if.rs1_i : '1;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end else if (fast_ovf) begin
                result_q <= div_if.div_op_i[1] ? '0 : div_if.rs1_i;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
`ifdef DIV_RESULT_CACHE_EN
              else if (hit) begin
                result_q <= div_if.div_op_i[1] ? c_rem_q : c_quo_q;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
`endif
              else begin
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              result_q <= rem_sel_q ? r_fix : q_fix;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign div_if.busy_o   = (state_q != IDLE);
  assign div_if.stall_o  = go || (state_q == CALC);
  assign div_if.done_o   = done_q;
  assign div_if.result_o = result_q;
endmodule
